alu_issue_stage: RTL and testbench

//  Decode + issue register feeding the ALU: turns RV32I opcode/funct fields and operands into

---
 rtl/alu_issue_stage_if.sv | 42 ++++
 rtl/alu_issue_stage.sv | 151 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Bus for the ALU issue stage: the ID-side request (valid_in/ready_out plus the
// decoded fields and operands) and the EX-side response (valid_out/ready_in plus
// the registered operands, control code, flag and issue counter).
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both 1. A producer holding valid=1 keeps its payload unchanged until that
// transfer. The ready signal may depend combinationally on the receiver's
// state, but never on the valid signal of the same channel.
interface alu_issue_stage_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 32
);
  logic              flush;
  logic              valid_in;
  logic              ready_out;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              funct7_b5;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] imm;
  logic              valid_out;
  logic              ready_in;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              illegal_out;
  logic [CNT_W-1:0]  ops_issued;

  // Environment view: drives the requests and the EX-side ready
  modport master (
    output flush, valid_in, opcode, funct3, funct7_b5, rs1_data, rs2_data, imm, ready_in,
    input  ready_out, valid_out, alu_a, alu_b, alu_ctrl, illegal_out, ops_issued
  );

  // Issue stage view
  modport slave (
    input  flush, valid_in, opcode, funct3, funct7_b5, rs1_data, rs2_data, imm, ready_in,
    output ready_out, valid_out, alu_a, alu_b, alu_ctrl, illegal_out, ops_issued
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes the RV32I opcode and funct fields into an ALU control
// code and operand pair, then holds them in a one-entry pipeline register between
// ID and EX. The register supports backpressure and flush.
// Optional feature macro: ALU_ILLEGAL_TRAP_EN. When it is defined, illegal_out is
// registered alongside each op. When it is undefined, illegal_out is tied to 0.
// In both builds an illegal op is still issued, with control code 1111.
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 32
) (
  input logic            clk,
  input logic            reset,
  alu_issue_stage_if.slave bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [CTRL_W-1:0] C_AND = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] C_OR  = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] C_ADD = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] C_SLL = CTRL_W'(4'b0011);
  localparam logic [CTRL_W-1:0] C_SUB = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] C_SRL = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] C_SRA = CTRL_W'(4'b1000);
  localparam logic [CTRL_W-1:0] C_ILL = CTRL_W'(4'b1111);

  logic [CTRL_W-1:0] w_ctrl;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_b_eff;
  logic              w_illegal;
  logic              w_shift;
  logic              w_load;
  logic              w_unload;

  logic              r_valid;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_cnt;

  // The stage accepts a new op whenever it is empty or the held op leaves this cycle
  assign bus.ready_out = !r_valid || bus.ready_in;
  assign w_unload      = r_valid && bus.ready_in;
  assign w_load        = bus.valid_in && bus.ready_out && !bus.flush;

  // Decode the opcode and funct fields into a control code and the b operand
  always_comb begin
    w_ctrl    = C_ILL;
    w_b       = bus.rs2_data;
    w_illegal = 1'b1;
    w_shift   = 1'b0;
    case (bus.opcode)
      OP_R: begin
        case (bus.funct3)
          3'b000: begin w_ctrl = bus.funct7_b5 ? C_SUB : C_ADD; w_illegal = 1'b0; end
          3'b111: begin w_ctrl = C_AND; w_illegal = 1'b0; end
          3'b110: begin w_ctrl = C_OR;  w_illegal = 1'b0; end
          3'b001: begin
            if (!bus.funct7_b5) begin
              w_ctrl = C_SLL; w_illegal = 1'b0; w_shift = 1'b1;
            end
          end
          3'b101: begin
            w_ctrl = bus.funct7_b5 ? C_SRA : C_SRL; w_illegal = 1'b0; w_shift = 1'b1;
          end
          default: ;
        endcase
      end
      OP_I: begin
        case (bus.funct3)
          3'b000: begin w_ctrl = C_ADD; w_b = bus.imm; w_illegal = 1'b0; end
          3'b111: begin w_ctrl = C_AND; w_b = bus.imm; w_illegal = 1'b0; end
          3'b110: begin w_ctrl = C_OR;  w_b = bus.imm; w_illegal = 1'b0; end
          3'b001: begin
            if (!bus.funct7_b5) begin
              w_ctrl = C_SLL; w_b = bus.imm; w_illegal = 1'b0; w_shift = 1'b1;
            end
          end
          3'b101: begin
            // imm[10] is instr[30], which selects arithmetic vs logical shift
            w_ctrl = bus.imm[10] ? C_SRA : C_SRL; w_b = bus.imm;
            w_illegal = 1'b0; w_shift = 1'b1;
          end
          default: ;
        endcase
      end
      OP_LOAD, OP_STORE: begin w_ctrl = C_ADD; w_b = bus.imm; w_illegal = 1'b0; end
      OP_BRANCH:         begin w_ctrl = C_SUB; w_illegal = 1'b0; end
      default: ;
    endcase
  end

  // For shifts, keep only the 5-bit shamt so a full-width shift in EX matches RV32 semantics
  always_comb begin
    w_b_eff = w_b;
    if (w_shift) w_b_eff[DATA_W-1:5] = '0;
  end

  // Pipeline register: flush drops the entry, a load replaces it, an unload empties it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_ctrl  <= C_ILL;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_a     <= bus.rs1_data;
      r_b     <= w_b_eff;
      r_ctrl  <= w_ctrl;
    end else if (w_unload) begin
      r_valid <= 1'b0;
    end
  end

  // Count completed output handshakes; the counter wraps naturally and ignores flush
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else if (w_unload) r_cnt <= r_cnt + 1'b1;
  end

`ifdef ALU_ILLEGAL_TRAP_EN
  logic r_illegal;

  // The illegal flag travels with its op so that EX can trap on it
  always_ff @(posedge clk) begin
    if (reset) r_illegal <= 1'b0;
    else if (!bus.flush && w_load) r_illegal <= w_illegal;
  end

  assign bus.illegal_out = r_illegal;
`else
  logic w_unused_illegal;
  assign w_unused_illegal = w_illegal;
  assign bus.illegal_out  = 1'b0;
`endif

  assign bus.valid_out  = r_valid;
  assign bus.alu_a      = r_a;
  assign bus.alu_b      = r_b;
  assign bus.alu_ctrl   = r_ctrl;
  assign bus.ops_issued = r_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a directed stimulus driver plus a scoreboard.
// Each accepted op pushes its hand-computed result into exp_q. A monitor pops
// exp_q on every output handshake and compares.
module tb_alu_issue_stage;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;
  localparam int CNT_W  = 32;
  localparam int W      = 2 * DATA_W + CTRL_W + 1;
`ifdef ALU_ILLEGAL_TRAP_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [W-1:0] exp_q[$];

  alu_issue_stage_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  alu_issue_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one op and hold it until the stage accepts it, pushing the expected result
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [31:0] exp_b, input logic [3:0] exp_ctrl, input logic exp_ill);
    bit done;
    done          = 1'b0;
    bus.flush     = 1'b0;
    bus.valid_in  = 1'b1;
    bus.opcode    = op;
    bus.funct3    = f3;
    bus.funct7_b5 = f7;
    bus.rs1_data  = rs1;
    bus.rs2_data  = rs2;
    bus.imm       = imm;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.ready_out) begin
        exp_q.push_back({rs1, exp_b, exp_ctrl, exp_ill & ILL_EN});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL issue_timeout: got ready_out=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: compare every output handshake with the head of exp_q
  always @(negedge clk) begin
    if (!reset && bus.valid_out && bus.ready_in) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_out: got a=0x%0h b=0x%0h ctrl=0x%0h expected none",
                 bus.alu_a, bus.alu_b, bus.alu_ctrl);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.illegal_out} !== e) begin
          n_errors++;
          $display("FAIL out_packet: got a=0x%0h b=0x%0h ctrl=0x%0h ill=%0b expected a=0x%0h b=0x%0h ctrl=0x%0h ill=%0b",
                   bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.illegal_out,
                   e[W-1 -: DATA_W], e[CTRL_W+DATA_W : CTRL_W+1], e[CTRL_W:1], e[0]);
        end
      end
    end
  end

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] exp_b;
    logic [3:0]  exp_ctrl;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{7'b0110011, 3'b000, 1'b0, 32'd5,   32'd7,        32'd0,        32'd7,        4'b0010, 1'b0};
    vecs[1]  = '{7'b0110011, 3'b001, 1'b0, 32'd1,   32'h123,      32'd0,        32'd3,        4'b0011, 1'b0};
    vecs[2]  = '{7'b0110011, 3'b101, 1'b0, 32'hF00, 32'hFFFFFFE3, 32'd0,        32'd3,        4'b0111, 1'b0};
    vecs[3]  = '{7'b0110011, 3'b101, 1'b1, 32'hF01, 32'h3F,       32'd0,        32'h1F,       4'b1000, 1'b0};
    vecs[4]  = '{7'b0110011, 3'b111, 1'b0, 32'hFF,  32'hF0F0,     32'd0,        32'hF0F0,     4'b0000, 1'b0};
    vecs[5]  = '{7'b0110011, 3'b110, 1'b0, 32'h11,  32'h22,       32'd0,        32'h22,       4'b0001, 1'b0};
    vecs[6]  = '{7'b0010011, 3'b000, 1'b0, 32'd9,   32'd1,        32'hFFFFFFFC, 32'hFFFFFFFC, 4'b0010, 1'b0};
    vecs[7]  = '{7'b0010011, 3'b111, 1'b0, 32'd10,  32'd1,        32'hFF,       32'hFF,       4'b0000, 1'b0};
    vecs[8]  = '{7'b0010011, 3'b110, 1'b0, 32'd11,  32'd1,        32'h10,       32'h10,       4'b0001, 1'b0};
    vecs[9]  = '{7'b0010011, 3'b001, 1'b0, 32'd12,  32'd1,        32'h7,        32'h7,        4'b0011, 1'b0};
    vecs[10] = '{7'b0010011, 3'b101, 1'b0, 32'd13,  32'd1,        32'h3,        32'h3,        4'b0111, 1'b0};
    vecs[11] = '{7'b0000011, 3'b010, 1'b0, 32'h100, 32'd1,        32'h40,       32'h40,       4'b0010, 1'b0};
    vecs[12] = '{7'b0100011, 3'b010, 1'b0, 32'h200, 32'd1,        32'hFFFFFFF0, 32'hFFFFFFF0, 4'b0010, 1'b0};
    vecs[13] = '{7'b1100011, 3'b000, 1'b0, 32'h99,  32'h99,       32'h8,        32'h99,       4'b0110, 1'b0};
    vecs[14] = '{7'b0110011, 3'b010, 1'b0, 32'd14,  32'h55,       32'd0,        32'h55,       4'b1111, 1'b1};
    vecs[15] = '{7'b0010011, 3'b011, 1'b0, 32'd15,  32'h66,       32'h12,       32'h66,       4'b1111, 1'b1};
  end

  // Directed stimulus
  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.valid_in  = 1'b0;
    bus.ready_in  = 1'b1;
    bus.opcode    = '0;
    bus.funct3    = '0;
    bus.funct7_b5 = 1'b0;
    bus.rs1_data  = '0;
    bus.rs2_data  = '0;
    bus.imm       = '0;

    repeat (3) step();
    check("rst_valid_out", 64'(bus.valid_out), 64'd0);
    check("rst_alu_a", 64'(bus.alu_a), 64'd0);
    check("rst_alu_b", 64'(bus.alu_b), 64'd0);
    check("rst_alu_ctrl", 64'(bus.alu_ctrl), 64'hF);
    check("rst_illegal", 64'(bus.illegal_out), 64'd0);
    check("rst_ops_issued", 64'(bus.ops_issued), 64'd0);
    check("rst_ready_out", 64'(bus.ready_out), 64'd1);
    reset = 1'b0;
    step();

    // R-type SUB
    issue(7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'd0, 32'd3, 4'b0110, 1'b0);
    bus.valid_in = 1'b0;
    check("sub_valid_out", 64'(bus.valid_out), 64'd1);
    check("sub_alu_ctrl", 64'(bus.alu_ctrl), 64'h6);
    step();
    check("sub_count", 64'(bus.ops_issued), 64'd1);
    check("sub_drained", 64'(bus.valid_out), 64'd0);

    // SRAI with imm[10] set: shamt masked to 5
    issue(7'b0010011, 3'b101, 1'b1, 32'h80000000, 32'd0, 32'h405, 32'd5, 4'b1000, 1'b0);
    bus.valid_in = 1'b0;
    check("srai_alu_b", 64'(bus.alu_b), 64'd5);
    step();
    check("srai_count", 64'(bus.ops_issued), 64'd2);

    // Back-to-back decode table
    foreach (vecs[i])
      issue(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
            vecs[i].exp_b, vecs[i].exp_ctrl, vecs[i].exp_ill);
    bus.valid_in = 1'b0;
    step();
    check("table_count", 64'(bus.ops_issued), 64'd18);

    // Backpressure: A held for two cycles while B waits
    bus.ready_in = 1'b0;
    issue(7'b0110011, 3'b111, 1'b0, 32'hAAAA, 32'h0F0F, 32'd0, 32'h0F0F, 4'b0000, 1'b0);
    bus.opcode   = 7'b0110011;
    bus.funct3   = 3'b110;
    bus.funct7_b5 = 1'b0;
    bus.rs1_data = 32'hBBBB;
    bus.rs2_data = 32'h1234;
    bus.valid_in = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      check("stall_ready_out", 64'(bus.ready_out), 64'd0);
      check("stall_valid_out", 64'(bus.valid_out), 64'd1);
      check("stall_alu_a", 64'(bus.alu_a), 64'hAAAA);
      check("stall_alu_b", 64'(bus.alu_b), 64'h0F0F);
      check("stall_count", 64'(bus.ops_issued), 64'd18);
    end
    bus.ready_in = 1'b1;
    exp_q.push_back({32'hBBBB, 32'h1234, 4'b0001, 1'b0});
    step();
    bus.valid_in = 1'b0;
    check("b2b_alu_a", 64'(bus.alu_a), 64'hBBBB);
    check("b2b_valid_out", 64'(bus.valid_out), 64'd1);
    check("b2b_count1", 64'(bus.ops_issued), 64'd19);
    step();
    check("b2b_count2", 64'(bus.ops_issued), 64'd20);

    // Flush drops held op C and ignores the incoming op
    bus.ready_in = 1'b0;
    issue(7'b0110111, 3'b000, 1'b0, 32'hCCCC, 32'h77, 32'h5000, 32'h77, 4'b1111, 1'b1);
    check("lui_alu_ctrl", 64'(bus.alu_ctrl), 64'hF);
    check("lui_illegal", 64'(bus.illegal_out), 64'(ILL_EN));
    bus.flush    = 1'b1;
    bus.valid_in = 1'b1;
    bus.opcode   = 7'b0110011;
    bus.funct3   = 3'b000;
    bus.rs1_data = 32'hDDDD;
    step();
    void'(exp_q.pop_back());
    bus.flush    = 1'b0;
    bus.valid_in = 1'b0;
    check("flush_valid_out", 64'(bus.valid_out), 64'd0);
    check("flush_count", 64'(bus.ops_issued), 64'd20);
    bus.ready_in = 1'b1;
    step();
    check("flush_no_load", 64'(bus.valid_out), 64'd0);
    check("flush_count2", 64'(bus.ops_issued), 64'd20);

    repeat (2) step();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
